sequence_hit_counter: RTL and testbench

//  Downstream stage of the Mealy sequence recognizer: samples its z output every clock,

---
 rtl/sequence_hit_counter.sv | 86 ++++++++
 tb/tb_sequence_hit_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_hit_counter.sv
// Counts recognizer hits over windows of WINDOW enabled clocks and hands each
// window total to a consumer through a single valid/ready register stage.
module sequence_hit_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             z,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  input  logic             ready,
  output logic             lost
);

  localparam int                WCNT_W = $clog2(WINDOW);
  localparam logic [WCNT_W-1:0] LAST   = WCNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  MAX    = '1;

  typedef enum logic {RUN, HOLD}   win_state_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

  win_state_t        win_state;
  out_state_t        out_state;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  res;
  logic              close;

  // The window only advances on enabled clocks; HOLD freezes wcnt and acc.
  assign win_state = enable ? RUN : HOLD;

  // Saturating accumulate: once at MAX, further hits are ignored.
  assign res   = (acc == MAX) ? acc : acc + CNT_W'(z);
  assign close = (win_state == RUN) && (wcnt == LAST);
  assign valid = (out_state == FULL);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let acc feed res in the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt      <= '0;
      acc       <= '0;
      count_out <= '0;
      out_state <= EMPTY;
      lost      <= 1'b0;
    end else if (clear) begin
      wcnt      <= '0;
      acc       <= '0;
      out_state <= EMPTY;
      lost      <= 1'b0;
    end else begin
      if (win_state == RUN) begin
        if (close) begin
          wcnt <= '0;
          acc  <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
          acc  <= res;
        end
      end

      case (out_state)
        EMPTY: begin
          if (close) begin
            count_out <= res;
            out_state <= FULL;
          end
        end
        FULL: begin
          // A close while the consumer stalls drops the new result, keeping
          // count_out stable for the pending transfer.
          if (close) begin
            if (ready) count_out <= res;
            else       lost      <= 1'b1;
          end else if (ready) begin
            out_state <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_hit_counter.sv
// Self-checking bench: directed vector table plus randomized run against a
// window-level reference model, on two parameterizations of the counter.
module tb_sequence_hit_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       z = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] count_a;
  logic       valid_a, lost_a;
  logic [1:0] count_b;
  logic       valid_b, lost_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sequence_hit_counter #(.CNT_W(8), .WINDOW(4)) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .z(z),
    .count_out(count_a), .valid(valid_a), .ready(ready), .lost(lost_a)
  );

  sequence_hit_counter #(.CNT_W(2), .WINDOW(8)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .z(z),
    .count_out(count_b), .valid(valid_b), .ready(ready), .lost(lost_b)
  );

  // Reference model: window position, raw hit total, saturation applied at close.
  int m_pos[2], m_sum[2], m_cnt[2];
  bit m_valid[2], m_lost[2];

  function automatic int win_of(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int max_of(int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_lost[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit closed = 0;
      int res = 0;
      if (clear) begin
        m_pos[i] = 0; m_sum[i] = 0; m_valid[i] = 0; m_lost[i] = 0;
      end else begin
        if (enable) begin
          if (m_pos[i] == win_of(i) - 1) begin
            res = m_sum[i] + int'(z);
            if (res > max_of(i)) res = max_of(i);
            closed = 1;
            m_pos[i] = 0;
            m_sum[i] = 0;
          end else begin
            m_pos[i]++;
            m_sum[i] += int'(z);
          end
        end
        if (closed) begin
          if (!m_valid[i] || ready) begin
            m_cnt[i] = res;
            m_valid[i] = 1;
          end else begin
            m_lost[i] = 1;
          end
        end else if (m_valid[i] && ready) begin
          m_valid[i] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    check("model_valid_a", 32'(valid_a), 32'(m_valid[0]));
    check("model_count_a", 32'(count_a), 32'(m_cnt[0]));
    check("model_lost_a",  32'(lost_a),  32'(m_lost[0]));
    check("model_valid_b", 32'(valid_b), 32'(m_valid[1]));
    check("model_count_b", 32'(count_b), 32'(m_cnt[1]));
    check("model_lost_b",  32'(lost_b),  32'(m_lost[1]));
  endtask

  // Inputs change only at negedge; model advances at posedge; outputs sampled at negedge.
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drive(bit c, bit e, bit zz, bit r);
    clear = c; enable = e; z = zz; ready = r;
  endtask

  typedef struct {
    bit       clr, en, zz, rdy;
    bit       exp_valid;
    int       exp_count;
    bit       exp_lost;
  } vec_t;

  vec_t tbl[35];

  initial begin
    // single-cycle valid, count 3 (z=1,1,0,1)
    tbl[0]  = '{0,1,1,1, 0,0,0};
    tbl[1]  = '{0,1,1,1, 0,0,0};
    tbl[2]  = '{0,1,0,1, 0,0,0};
    tbl[3]  = '{0,1,1,1, 1,3,0};
    tbl[4]  = '{0,0,0,1, 0,3,0};
    // backpressure across two windows: 4 held, lost after second close
    tbl[5]  = '{0,1,1,0, 0,3,0};
    tbl[6]  = '{0,1,1,0, 0,3,0};
    tbl[7]  = '{0,1,1,0, 0,3,0};
    tbl[8]  = '{0,1,1,0, 1,4,0};
    tbl[9]  = '{0,1,0,0, 1,4,0};
    tbl[10] = '{0,1,0,0, 1,4,0};
    tbl[11] = '{0,1,0,0, 1,4,0};
    tbl[12] = '{0,1,0,0, 1,4,1};
    // clear drops valid and lost, count_out kept
    tbl[13] = '{1,1,1,0, 0,4,0};
    // ready on the closing edge while FULL: new value, valid stays, no loss
    tbl[14] = '{0,1,1,0, 0,4,0};
    tbl[15] = '{0,1,0,0, 0,4,0};
    tbl[16] = '{0,1,0,0, 0,4,0};
    tbl[17] = '{0,1,0,0, 1,1,0};
    tbl[18] = '{0,1,1,0, 1,1,0};
    tbl[19] = '{0,1,1,0, 1,1,0};
    tbl[20] = '{0,1,0,0, 1,1,0};
    tbl[21] = '{0,1,0,1, 1,2,0};
    // enable gap mid-window: gap hits ignored, close delayed
    tbl[22] = '{0,1,1,1, 0,2,0};
    tbl[23] = '{0,0,1,1, 0,2,0};
    tbl[24] = '{0,0,1,1, 0,2,0};
    tbl[25] = '{0,0,1,1, 0,2,0};
    tbl[26] = '{0,1,1,1, 0,2,0};
    tbl[27] = '{0,1,1,1, 0,2,0};
    tbl[28] = '{0,1,0,1, 1,3,0};
    // enable low at the boundary does not close the window
    tbl[29] = '{0,1,1,0, 1,3,0};
    tbl[30] = '{0,1,1,0, 1,3,0};
    tbl[31] = '{0,1,1,0, 1,3,0};
    tbl[32] = '{0,0,1,0, 1,3,0};
    tbl[33] = '{0,1,1,1, 1,4,0};
    tbl[34] = '{0,1,0,1, 0,4,0};

    @(negedge clock);
    do_reset();
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_count", 32'(count_a), 32'd0);
    check("reset_lost",  32'(lost_a),  32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].en, tbl[i].zz, tbl[i].rdy);
      cycle();
      check($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_count", i), 32'(count_a), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_lost", i),  32'(lost_a),  32'(tbl[i].exp_lost));
    end

    // Saturation on the narrow instance: 8 hits into a 2-bit count
    do_reset();
    repeat (8) begin
      drive(0, 1, 1, 1);
      cycle();
    end
    check("sat_valid_b", 32'(valid_b), 32'd1);
    check("sat_count_b", 32'(count_b), 32'd3);
    check("sat_lost_b",  32'(lost_b),  32'd0);

    // Async reset mid-window with a pending result
    do_reset();
    repeat (4) begin
      drive(0, 1, 1, 0);
      cycle();
    end
    check("pre_rst_valid", 32'(valid_a), 32'd1);
    repeat (2) begin
      drive(0, 1, 1, 0);
      cycle();
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_valid", 32'(valid_a), 32'd0);
    check("async_rst_count", 32'(count_a), 32'd0);
    check("async_rst_lost",  32'(lost_a),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 0), 0);
      cycle();
    end
    check("post_rst_valid", 32'(valid_a), 32'd1);
    check("post_rst_count", 32'(count_a), 32'd1);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
            1'($urandom), ($urandom_range(0, 3) != 0));
      if (i % 1000 == 500) begin
        drive(0, 1, 1, 0);
        repeat (40) cycle();
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
